// File: rtl/temp_cal_pkg.sv
// Constants and types shared by the forward temperature calculator and its
// inverse (temperature_to_adc).
package temp_cal_pkg;

    localparam int unsigned BASE_W = 32;
    localparam int unsigned REF_W  = 8;
    localparam int unsigned ADC_W  = 16;

    localparam logic [ADC_W-1:0] ADC_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        DIV,
        DONE
    } state_t;

endpackage

// File: rtl/seq_divider.sv
// Generic unsigned restoring divider, one quotient bit per clock, MSB first.
// done marks the cycle whose closing edge completes the last step.
module seq_divider #(
    parameter int unsigned DVD_W = 32,
    parameter int unsigned DSR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DSR_W-1:0] divisor,
    output logic             done,
    output logic [DVD_W-1:0] quotient,
    output logic [DSR_W-1:0] remainder
);

    localparam int unsigned CNT_W = (DVD_W > 1) ? $clog2(DVD_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DVD_W - 1);

    // dvd_q shifts dividend bits out of the top while quotient bits enter at the bottom
    logic [DVD_W-1:0] dvd_q;
    logic [DSR_W-1:0] dsr_q;
    logic [DSR_W-1:0] rem_q;
    logic [CNT_W-1:0] count_q;
    logic             running_q;

    logic [DSR_W:0]   rem_sh;
    logic             fits;
    logic [DSR_W-1:0] rem_nx;
    logic [DVD_W-1:0] quo_nx;

    always_comb begin
        rem_sh = {rem_q, dvd_q[DVD_W-1]};
        fits   = (rem_sh >= {1'b0, dsr_q});
        rem_nx = fits ? DSR_W'(rem_sh - {1'b0, dsr_q}) : rem_sh[DSR_W-1:0];
        quo_nx = {dvd_q[DVD_W-2:0], fits};
    end

    assign done      = running_q && (count_q == LAST);
    assign quotient  = quo_nx;
    assign remainder = rem_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_q     <= '0;
            dsr_q     <= '0;
            rem_q     <= '0;
            count_q   <= '0;
            running_q <= 1'b0;
        end else if (start) begin
            dvd_q     <= dividend;
            dsr_q     <= divisor;
            rem_q     <= '0;
            count_q   <= '0;
            running_q <= 1'b1;
        end else if (running_q) begin
            dvd_q   <= quo_nx;
            rem_q   <= rem_nx;
            count_q <= count_q + 1'b1;
            if (count_q == LAST) begin
                running_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/temperature_to_adc.sv
// Inverse temperature conversion: adc_data = (tempc - tc_base) / tc_ref,
// with range checks, saturation and a start/busy/done handshake.
module temperature_to_adc #(
    parameter int unsigned BASE_W = temp_cal_pkg::BASE_W,
    parameter int unsigned REF_W  = temp_cal_pkg::REF_W,
    parameter int unsigned ADC_W  = temp_cal_pkg::ADC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BASE_W-1:0] tempc,
    input  logic [BASE_W-1:0] tc_base,
    input  logic [REF_W-1:0]  tc_ref,
    output logic              busy,
    output logic              done,
    output logic [ADC_W-1:0]  adc_data,
    output logic [REF_W-1:0]  remainder,
    output logic              err_under,
    output logic              err_div0,
    output logic              sat
);

    import temp_cal_pkg::state_t;
    import temp_cal_pkg::IDLE;
    import temp_cal_pkg::CHECK;
    import temp_cal_pkg::DIV;
    import temp_cal_pkg::DONE;

    state_t state_q, state_d;

    logic [BASE_W-1:0] tempc_q;
    logic [BASE_W-1:0] base_q;
    logic [REF_W-1:0]  ref_q;

    logic [BASE_W:0]   diff_ext;
    logic [BASE_W-1:0] diff;
    logic              borrow;
    logic              ref_zero;
    logic              div_start;
    logic              div_done;
    logic [BASE_W-1:0] div_quo;
    logic [REF_W-1:0]  div_rem;
    logic              quo_ovf;

    // The borrow out of the widened subtraction is the underflow condition
    assign diff_ext  = {1'b0, tempc_q} - {1'b0, base_q};
    assign borrow    = diff_ext[BASE_W];
    assign diff      = diff_ext[BASE_W-1:0];
    assign ref_zero  = (ref_q == '0);
    assign div_start = (state_q == CHECK) && !ref_zero && !borrow;
    assign quo_ovf   = |div_quo[BASE_W-1:ADC_W];

    seq_divider #(
        .DVD_W(BASE_W),
        .DSR_W(REF_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (diff),
        .divisor  (ref_q),
        .done     (div_done),
        .quotient (div_quo),
        .remainder(div_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CHECK;
            CHECK:   state_d = (ref_zero || borrow) ? DONE : DIV;
            DIV:     if (div_done) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tempc_q   <= '0;
            base_q    <= '0;
            ref_q     <= '0;
            adc_data  <= '0;
            remainder <= '0;
            err_under <= 1'b0;
            err_div0  <= 1'b0;
            sat       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        tempc_q   <= tempc;
                        base_q    <= tc_base;
                        ref_q     <= tc_ref;
                        adc_data  <= '0;
                        remainder <= '0;
                        err_under <= 1'b0;
                        err_div0  <= 1'b0;
                        sat       <= 1'b0;
                    end
                end
                CHECK: begin
                    // adc_data/remainder were already zeroed at acceptance
                    if (ref_zero) begin
                        err_div0 <= 1'b1;
                    end else if (borrow) begin
                        err_under <= 1'b1;
                    end
                end
                DIV: begin
                    if (div_done) begin
                        adc_data  <= quo_ovf ? '1 : div_quo[ADC_W-1:0];
                        remainder <= div_rem;
                        sat       <= quo_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_temperature_to_adc.sv
// Scoreboard bench for temperature_to_adc: expected results are queued at
// stimulus time and compared by a monitor whenever done is seen.
module tb_temperature_to_adc;

    typedef struct packed {
        logic [15:0] adc;
        logic [7:0]  rem;
        logic        under;
        logic        div0;
        logic        sat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] tempc = '0;
    logic [31:0] tc_base = '0;
    logic [7:0]  tc_ref = '0;
    logic        busy, done, err_under, err_div0, sat;
    logic [15:0] adc_data;
    logic [7:0]  remainder;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   lat, bc, nd;

    temperature_to_adc dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .tempc    (tempc),
        .tc_base  (tc_base),
        .tc_ref   (tc_ref),
        .busy     (busy),
        .done     (done),
        .adc_data (adc_data),
        .remainder(remainder),
        .err_under(err_under),
        .err_div0 (err_div0),
        .sat      (sat)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] t, input logic [31:0] b, input logic [7:0] r);
        exp_t        e;
        logic [31:0] q;
        e = '0;
        if (r == 8'd0) begin
            e.div0 = 1'b1;
        end else if (t < b) begin
            e.under = 1'b1;
        end else begin
            q     = (t - b) / {24'd0, r};
            e.rem = 8'((t - b) % {24'd0, r});
            if (q > 32'(temp_cal_pkg::ADC_MAX)) begin
                e.adc = 16'hFFFF;
                e.sat = 1'b1;
            end else begin
                e.adc = q[15:0];
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done=1 want no pending result");
            end else begin
                mon_e = sb.pop_front();
                checks++;
                if (adc_data !== mon_e.adc) begin
                    errors++;
                    $display("FAIL adc_data: got %h want %h", adc_data, mon_e.adc);
                end
                checks++;
                if (remainder !== mon_e.rem) begin
                    errors++;
                    $display("FAIL remainder: got %0d want %0d", remainder, mon_e.rem);
                end
                checks++;
                if ({err_under, err_div0, sat} !== {mon_e.under, mon_e.div0, mon_e.sat}) begin
                    errors++;
                    $display("FAIL flags(under,div0,sat): got %b want %b",
                             {err_under, err_div0, sat}, {mon_e.under, mon_e.div0, mon_e.sat});
                end
            end
        end
    end

    // Drives one request and measures done latency (edge index after the
    // accepting edge), busy duration and done count. A second start pulse is
    // raised at negedge restart_k when restart_k >= 0.
    task automatic run_op(input logic [31:0] t, input logic [31:0] b, input logic [7:0] r,
                          input int restart_k, output int l, output int bcyc, output int ndone);
        l = -1;
        bcyc = 0;
        ndone = 0;
        sb.push_back(model(t, b, r));
        @(negedge clk);
        tempc = t;
        tc_base = b;
        tc_ref = r;
        start = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k == 0 || (restart_k >= 0 && k == restart_k + 1)) start = 1'b0;
            if (k == 0) begin
                tempc = $urandom;
                tc_base = $urandom;
                tc_ref = 8'($urandom);
            end
            if (k == restart_k) begin
                start = 1'b1;
                tempc = 32'd5000;
                tc_base = 32'd0;
                tc_ref = 8'd1;
            end
            if (busy) bcyc++;
            if (done) begin
                ndone++;
                if (l < 0) l = k;
            end
            if (l >= 0 && !busy) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err_under, err_div0, sat} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000", {busy, done, err_under, err_div0, sat});
        end
        checks++;
        if ({adc_data, remainder} !== 24'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 000000", {adc_data, remainder});
        end
        rst = 1'b0;
    endtask

    task automatic test_round_trip;
        exp_t e;
        e = model(32'd2871962150, 32'hAAAAAAAA, 8'hC6);
        run_op(32'd2871962150, 32'hAAAAAAAA, 8'hC6, -1, lat, bc, nd);
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL rt_latency: got %0d want 33", lat); end
        checks++;
        if (bc !== 34) begin errors++; $display("FAIL rt_busy_cycles: got %0d want 34", bc); end
        checks++;
        if (nd !== 1) begin errors++; $display("FAIL rt_done_count: got %0d want 1", nd); end
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, adc_data} !== {2'b00, e.adc}) begin
            errors++;
            $display("FAIL rt_hold: got busy=%b done=%b adc=%h want 0 0 %h", busy, done, adc_data, e.adc);
        end
    endtask

    task automatic test_remainder;
        run_op(32'd2871962155, 32'hAAAAAAAA, 8'hC6, -1, lat, bc, nd);
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL rem_latency: got %0d want 33", lat); end
    endtask

    task automatic test_errors;
        run_op(32'hAAAAAAA9, 32'hAAAAAAAA, 8'hC6, -1, lat, bc, nd);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL under_latency: got %0d want 1", lat); end
        checks++;
        if (bc !== 2) begin errors++; $display("FAIL under_busy_cycles: got %0d want 2", bc); end
        run_op(32'hFFFFFFFF, 32'hAAAAAAAA, 8'h00, -1, lat, bc, nd);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL div0_latency: got %0d want 1", lat); end
        // both error conditions at once: div0 must win
        run_op(32'd5, 32'd10, 8'h00, -1, lat, bc, nd);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL div0_prio_latency: got %0d want 1", lat); end
    endtask

    task automatic test_saturation;
        run_op(32'd71000, 32'd1000, 8'd1, -1, lat, bc, nd);
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL sat_latency: got %0d want 33", lat); end
        run_op(32'd1000 + 32'd65535, 32'd1000, 8'd1, -1, lat, bc, nd);
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL nosat_latency: got %0d want 33", lat); end
        run_op(32'd1000 + 32'd65536, 32'd1000, 8'd1, -1, lat, bc, nd);
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL sat_edge_latency: got %0d want 33", lat); end
    endtask

    task automatic test_back_to_back;
        run_op(32'd123456789, 32'd1000, 8'd77, 9, lat, bc, nd);
        checks++;
        if (nd !== 1) begin errors++; $display("FAIL restart_done_count: got %0d want 1", nd); end
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL restart_latency: got %0d want 33", lat); end
        // start raised during the DONE cycle must be dropped
        run_op(32'd999999, 32'd0, 8'd200, 33, lat, bc, nd);
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL done_cycle_start: got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_abort;
        bit saw_done;
        saw_done = 1'b0;
        @(negedge clk);
        tempc = 32'd50000;
        tc_base = 32'd100;
        tc_ref = 8'd3;
        start = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (k == 19) rst = 1'b1;
            if (k == 20) begin
                checks++;
                if ({busy, done, err_under, err_div0, sat, adc_data, remainder} !== 29'h0) begin
                    errors++;
                    $display("FAIL abort_outputs: got busy=%b done=%b adc=%h rem=%h flags=%b want all 0",
                             busy, done, adc_data, remainder, {err_under, err_div0, sat});
                end
                rst = 1'b0;
            end
            if (k > 20 && done) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got done after abort want none"); end
        run_op(32'd50000, 32'd100, 8'd3, -1, lat, bc, nd);
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL post_abort_latency: got %0d want 33", lat); end
    endtask

    task automatic test_boundary;
        run_op(32'd0, 32'd0, 8'hFF, -1, lat, bc, nd);
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL zero_latency: got %0d want 33", lat); end
        run_op(32'h8000_0000, 32'h8000_0000, 8'd7, -1, lat, bc, nd);
        run_op(32'hFFFF_FFFF, 32'd0, 8'hFF, -1, lat, bc, nd);
        for (int i = 0; i < 4; i++) begin
            run_op($urandom, $urandom_range(0, 32'h0FFF_FFFF), 8'($urandom_range(1, 255)), -1, lat, bc, nd);
        end
    endtask

    initial begin
        test_reset;
        test_round_trip;
        test_remainder;
        test_errors;
        test_saturation;
        test_back_to_back;
        test_reset_abort;
        test_boundary;
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
